mem_rd_arbiter: RTL and testbench

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_rd_arbiter_if.sv | 39 +++
 rtl/mem_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_rd_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rd_arbiter_if.sv
// Bundles the two requester address-FIFO ports, the destination-room flags,
// the memory read port, the routed read data and status for mem_rd_arbiter.
interface mem_rd_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DW         = 256
);
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic                  a_empty_i;
  logic                  a_pop_o;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic                  b_empty_i;
  logic                  b_pop_o;
  logic                  a_dfull_i;
  logic                  b_dfull_i;
  logic                  mem_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rvalid_i;
  logic [DW-1:0]         mem_rdata_i;
  logic [DW-1:0]         a_data_o;
  logic                  a_data_valid_o;
  logic [DW-1:0]         b_data_o;
  logic                  b_data_valid_o;
  logic                  err_o;
  logic                  idle_o;

  modport slave (
    input  a_addr_i, a_empty_i, b_addr_i, b_empty_i, a_dfull_i, b_dfull_i,
           mem_rvalid_i, mem_rdata_i,
    output a_pop_o, b_pop_o, mem_rd_o, mem_addr_o, a_data_o, a_data_valid_o,
           b_data_o, b_data_valid_o, err_o, idle_o
  );

  modport master (
    output a_addr_i, a_empty_i, b_addr_i, b_empty_i, a_dfull_i, b_dfull_i,
           mem_rvalid_i, mem_rdata_i,
    input  a_pop_o, b_pop_o, mem_rd_o, mem_addr_o, a_data_o, a_data_valid_o,
           b_data_o, b_data_valid_o, err_o, idle_o
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin read arbiter for two address FIFOs sharing one in-order memory
// read port; a tag FIFO remembers which requester each returned word belongs to.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned BUS_WIDTH_BYTES = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic            clk,
  input logic            reset_n,
  mem_rd_arbiter_if.slave bus
);
  localparam int unsigned DW = 8 * BUS_WIDTH_BYTES;
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  logic [CW-1:0]              outstanding_q, outstanding_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  req_e                       last_grant_q, last_grant_d;
  logic                       mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]              a_data_q, a_data_d;
  logic [DW-1:0]              b_data_q, b_data_d;
  logic                       a_valid_q, a_valid_d;
  logic                       b_valid_q, b_valid_d;
  logic                       err_q, err_d;

  logic rvalid_ok;
  logic room;
  logic a_elig, b_elig;
  logic grant_a, grant_b, grant;
  logic pop_id;

  // A genuine return frees its slot in the same cycle, so a full arbiter can
  // still issue one read while a word comes back (tag FIFO pops before it pushes).
  always_comb begin
    rvalid_ok = bus.mem_rvalid_i & (outstanding_q != '0);
    room      = (outstanding_q < CW'(MAX_OUTSTANDING)) | rvalid_ok;
    a_elig    = ~bus.a_empty_i & ~bus.a_dfull_i & room;
    b_elig    = ~bus.b_empty_i & ~bus.b_dfull_i & room;
    grant_a   = a_elig & (~b_elig | (last_grant_q == REQ_B));
    grant_b   = b_elig & (~a_elig | (last_grant_q == REQ_A));
    grant     = grant_a | grant_b;
    pop_id    = tag_q[rd_ptr_q];
  end

  always_comb begin
    outstanding_d = outstanding_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_d         = tag_q;
    last_grant_d  = last_grant_q;
    mem_rd_d      = grant;
    mem_addr_d    = mem_addr_q;
    a_data_d      = a_data_q;
    b_data_d      = b_data_q;
    a_valid_d     = 1'b0;
    b_valid_d     = 1'b0;
    err_d         = err_q | (bus.mem_rvalid_i & (outstanding_q == '0));

    if (grant) begin
      last_grant_d    = grant_b ? REQ_B : REQ_A;
      mem_addr_d      = grant_b ? bus.b_addr_i : bus.a_addr_i;
      tag_d[wr_ptr_q] = grant_b;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (rvalid_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (pop_id) begin
        b_valid_d = 1'b1;
        b_data_d  = bus.mem_rdata_i;
      end else begin
        a_valid_d = 1'b1;
        a_data_d  = bus.mem_rdata_i;
      end
    end

    case ({grant, rvalid_ok})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_q         <= '0;
      last_grant_q  <= REQ_A;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      a_data_q      <= '0;
      b_data_q      <= '0;
      a_valid_q     <= 1'b0;
      b_valid_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_q         <= tag_d;
      last_grant_q  <= last_grant_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      a_data_q      <= a_data_d;
      b_data_q      <= b_data_d;
      a_valid_q     <= a_valid_d;
      b_valid_q     <= b_valid_d;
      err_q         <= err_d;
    end
  end

  assign bus.a_pop_o        = grant_a;
  assign bus.b_pop_o        = grant_b;
  assign bus.mem_rd_o       = mem_rd_q;
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.a_data_o       = a_data_q;
  assign bus.a_data_valid_o = a_valid_q;
  assign bus.b_data_o       = b_data_q;
  assign bus.b_data_valid_o = b_valid_q;
  assign bus.err_o          = err_q;
  assign bus.idle_o         = (outstanding_q == '0) & bus.a_empty_i & bus.b_empty_i & ~mem_rd_q;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Randomized bench for mem_rd_arbiter: an in-order memory model plus a
// queue-based reference of issued reads predicts pops, strobes and routed data.
module tb_mem_rd_arbiter;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 64;
  localparam int unsigned MAXO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_rd_arbiter_if #(.ADDR_WIDTH(AW), .DW(DW)) bus ();

  mem_rd_arbiter #(
    .ADDR_WIDTH(AW),
    .BUS_WIDTH_BYTES(8),
    .MAX_OUTSTANDING(MAXO)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference state: ids of issued-but-unreturned reads, oldest first
  bit          tagq[$];
  int          memq[$];
  bit          last_b;
  bit          exp_mem_rd;
  logic [AW-1:0] exp_addr;
  bit          exp_av, exp_bv, exp_err;
  logic [DW-1:0] exp_ad, exp_bd;
  int          cyc;
  int          stall_pct;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    tagq.delete();
    memq.delete();
    last_b     = 1'b0;
    exp_mem_rd = 1'b0;
    exp_addr   = '0;
    exp_av     = 1'b0;
    exp_bv     = 1'b0;
    exp_err    = 1'b0;
    exp_ad     = '0;
    exp_bd     = '0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_mem_rd"},   64'(bus.mem_rd_o),       64'(exp_mem_rd));
    check({pfx, "_mem_addr"}, 64'(bus.mem_addr_o),     64'(exp_addr));
    check({pfx, "_a_valid"},  64'(bus.a_data_valid_o), 64'(exp_av));
    check({pfx, "_b_valid"},  64'(bus.b_data_valid_o), 64'(exp_bv));
    check({pfx, "_a_data"},   64'(bus.a_data_o),       64'(exp_ad));
    check({pfx, "_b_data"},   64'(bus.b_data_o),       64'(exp_bd));
    check({pfx, "_err"},      64'(bus.err_o),          64'(exp_err));
  endtask

  task automatic quiet_inputs();
    bus.a_empty_i    = 1'b1;
    bus.b_empty_i    = 1'b1;
    bus.a_dfull_i    = 1'b0;
    bus.b_dfull_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset_n = 1'b0;
    #1;
    clear_model();
    check_regs("rst");
    check("rst_idle", 64'(bus.idle_o), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1 cyc = 0;
  endtask

  // in-order memory: a read may return two cycles after its strobe at the earliest
  task automatic drive_mem();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = {$urandom, $urandom};
    if (memq.size() > 0 && cyc >= memq[0] + 2 && $urandom_range(99) >= stall_pct) begin
      bus.mem_rvalid_i = 1'b1;
      void'(memq.pop_front());
    end
  endtask

  task automatic step();
    int n;
    bit rv_ok, room, ea, eb, ga, gb, id;
    #1;
    n     = tagq.size();
    rv_ok = bus.mem_rvalid_i && n > 0;
    room  = (n - (rv_ok ? 1 : 0)) < MAXO;
    ea    = !bus.a_empty_i && !bus.a_dfull_i && room;
    eb    = !bus.b_empty_i && !bus.b_dfull_i && room;
    if (ea && eb) begin
      gb = !last_b;
      ga = last_b;
    end else begin
      ga = ea;
      gb = eb;
    end
    check("a_pop", 64'(bus.a_pop_o), 64'(ga));
    check("b_pop", 64'(bus.b_pop_o), 64'(gb));
    check("idle",  64'(bus.idle_o),
          64'(n == 0 && bus.a_empty_i && bus.b_empty_i && !exp_mem_rd));

    exp_av = 1'b0;
    exp_bv = 1'b0;
    if (bus.mem_rvalid_i) begin
      if (n == 0) exp_err = 1'b1;
      else begin
        id = tagq.pop_front();
        if (id) begin exp_bv = 1'b1; exp_bd = bus.mem_rdata_i; end
        else    begin exp_av = 1'b1; exp_ad = bus.mem_rdata_i; end
      end
    end
    exp_mem_rd = ga || gb;
    if (ga || gb) begin
      tagq.push_back(gb);
      last_b   = gb;
      exp_addr = gb ? bus.b_addr_i : bus.a_addr_i;
    end

    @(posedge clk);
    #1;
    cyc++;
    if (exp_mem_rd) memq.push_back(cyc);
    check_regs("reg");
  endtask

  initial begin
    bus.a_addr_i    = '0;
    bus.b_addr_i    = '0;
    bus.mem_rdata_i = '0;
    stall_pct       = 0;
    cyc             = 0;
    #1;
    do_reset();

    // single A request at 0x0100, fixed two-cycle memory latency
    for (int c = 0; c < 7; c++) begin
      quiet_inputs();
      bus.a_empty_i = (c != 0);
      bus.a_addr_i  = 16'h0100;
      drive_mem();
      step();
      if (c == 0) begin
        check("lat_mem_rd", 64'(bus.mem_rd_o), 64'd1);
        check("lat_addr",   64'(bus.mem_addr_o), 64'h0100);
      end
      if (c == 3) check("lat_a_valid", 64'(bus.a_data_valid_o), 64'd1);
      check("lat_b_valid", 64'(bus.b_data_valid_o), 64'd0);
    end

    // both requesters busy from reset: B must win the first tie
    do_reset();
    quiet_inputs();
    bus.a_empty_i = 1'b0;
    bus.b_empty_i = 1'b0;
    #1;
    check("first_tie_b", 64'(bus.b_pop_o), 64'd1);

    // randomized traffic in phases of stall / backpressure intensity
    for (int c = 0; c < 3000; c++) begin
      int dfa, dfb;
      if (c % 150 == 0) begin
        stall_pct = (c % 600 == 300) ? 100 : $urandom_range(60);
      end
      dfa = (c % 900 < 150) ? 0 : 20;
      dfb = (c % 900 < 150) ? 100 : 20;
      bus.a_empty_i = ($urandom_range(99) < 25);
      bus.b_empty_i = ($urandom_range(99) < 25);
      bus.a_dfull_i = ($urandom_range(99) < dfa);
      bus.b_dfull_i = ($urandom_range(99) < dfb);
      bus.a_addr_i  = AW'($urandom);
      bus.b_addr_i  = AW'($urandom);
      drive_mem();
      step();
    end

    // reset with reads still in flight, then a stray return must flag an error
    stall_pct = 100;
    for (int c = 0; c < 4; c++) begin
      quiet_inputs();
      bus.a_empty_i = 1'b0;
      bus.a_addr_i  = AW'($urandom);
      drive_mem();
      step();
    end
    do_reset();
    quiet_inputs();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = {$urandom, $urandom};
    step();
    check("spurious_err", 64'(bus.err_o), 64'd1);
    for (int c = 0; c < 3; c++) begin
      quiet_inputs();
      step();
    end
    do_reset();
    check("err_cleared", 64'(bus.err_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
